// File: rtl/alu_shared_sequencer.sv
// Time-shares one external combinational ALU between two requesters.
// Round-robin grant, registered ALU inputs, per-opcode settle count, valid/ready response.
module alu_shared_sequencer #(
  parameter int WIDTH   = 128,
  parameter int SHW     = 5,
  parameter int MUL_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_opcode,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [SHW-1:0]   req0_shift,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_opcode,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [SHW-1:0]   req1_shift,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_input1,
  output logic [WIDTH-1:0] alu_input2,
  output logic [SHW-1:0]   alu_shift,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_ovf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_ovf,
  output logic             rsp_err,
  output logic             busy
);

  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [7:0] MUL_CNT = 8'(MUL_LAT);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_reg;
  logic [7:0]       cnt_reg;
  logic             last_grant_reg;
  logic             grant0;
  logic             grant1;
  logic [3:0]       sel_opcode;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [SHW-1:0]   sel_shift;

  // On a tie, the requester that did not win last time gets the slot.
  always_comb begin
    grant0     = req0_valid && (!req1_valid || last_grant_reg);
    grant1     = req1_valid && (!req0_valid || !last_grant_reg);
    sel_opcode = grant1 ? req1_opcode : req0_opcode;
    sel_a      = grant1 ? req1_a      : req0_a;
    sel_b      = grant1 ? req1_b      : req0_b;
    sel_shift  = grant1 ? req1_shift  : req0_shift;
  end

  assign req0_ready = (state_reg == IDLE) && grant0;
  assign req1_ready = (state_reg == IDLE) && grant1;
  assign rsp_valid  = (state_reg == RESP);
  assign busy       = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= 8'd0;
      last_grant_reg <= 1'b1;
      alu_opcode     <= 4'd0;
      alu_input1     <= '0;
      alu_input2     <= '0;
      alu_shift      <= '0;
      rsp_id         <= 1'b0;
      rsp_result     <= '0;
      rsp_carry      <= 1'b0;
      rsp_zero       <= 1'b0;
      rsp_ovf        <= 1'b0;
      rsp_err        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant0 || grant1) begin
            alu_opcode     <= sel_opcode;
            alu_input1     <= sel_a;
            alu_input2     <= sel_b;
            alu_shift      <= sel_shift;
            rsp_id         <= grant1;
            last_grant_reg <= grant1;
            // Opcodes 8..15 skip the ALU and answer immediately with an error.
            if (sel_opcode[3]) begin
              state_reg  <= RESP;
              rsp_err    <= 1'b1;
              rsp_result <= '0;
              rsp_carry  <= 1'b0;
              rsp_zero   <= 1'b0;
              rsp_ovf    <= 1'b0;
            end else begin
              state_reg <= EXEC;
              cnt_reg   <= (sel_opcode == OP_MUL) ? MUL_CNT : 8'd1;
            end
          end
        end
        EXEC: begin
          cnt_reg <= cnt_reg - 8'd1;
          if (cnt_reg == 8'd1) begin
            state_reg  <= RESP;
            rsp_result <= alu_result;
            rsp_carry  <= alu_carry;
            rsp_zero   <= alu_zero;
            rsp_ovf    <= alu_ovf;
            rsp_err    <= 1'b0;
          end
        end
        RESP: begin
          if (rsp_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_shared_sequencer.sv
// Scoreboard bench for alu_shared_sequencer with a behavioural ALU attached to its alu_* port.
module tb_alu_shared_sequencer;

  localparam int WIDTH   = 128;
  localparam int SHW     = 5;
  localparam int MUL_LAT = 4;

  typedef struct packed {
    logic             id;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             ovf;
    logic             err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_opcode, req1_opcode, alu_opcode;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b, alu_input1, alu_input2, alu_result;
  logic [SHW-1:0] req0_shift, req1_shift, alu_shift;
  logic alu_carry, alu_zero, alu_ovf;
  logic rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_zero, rsp_ovf, rsp_err, busy;
  logic [WIDTH-1:0] rsp_result;

  int tests_run = 0;
  int fails = 0;
  rsp_t exp_q[$];

  always #5 clk = ~clk;

  alu_shared_sequencer #(.WIDTH(WIDTH), .SHW(SHW), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b), .req0_shift(req0_shift),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b), .req1_shift(req1_shift),
    .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
    .alu_shift(alu_shift), .alu_result(alu_result), .alu_carry(alu_carry),
    .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
    .rsp_ovf(rsp_ovf), .rsp_err(rsp_err), .busy(busy)
  );

  // Behavioural ALU standing in for the shared datapath.
  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b0;
    alu_ovf    = 1'b0;
    case (alu_opcode)
      4'd0: alu_result = alu_input1 << alu_shift;
      4'd1: alu_result = ($signed(alu_input1) > $signed(alu_input2)) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
      4'd2: alu_result = (alu_input1 >> alu_shift) | (alu_input1 << (WIDTH - int'(alu_shift)));
      4'd3: alu_result = alu_input1 * alu_input2;
      4'd4: alu_result = alu_input2;
      4'd5: alu_result = alu_input1 & alu_input2;
      4'd6: begin
        {alu_carry, alu_result} = {1'b0, alu_input1} + {1'b0, alu_input2};
        alu_ovf = (alu_input1[WIDTH-1] == alu_input2[WIDTH-1]) && (alu_result[WIDTH-1] != alu_input1[WIDTH-1]);
      end
      4'd7: alu_result = alu_input1 ^ alu_input2;
      default: alu_result = '0;
    endcase
  end
  assign alu_zero = (alu_result == '0);

  function automatic rsp_t mk_rsp(input logic id, input logic [WIDTH-1:0] res,
                                  input logic c, input logic z, input logic o, input logic e);
    rsp_t r;
    r.id = id; r.result = res; r.carry = c; r.zero = z; r.ovf = o; r.err = e;
    return r;
  endfunction

  function automatic rsp_t cur_rsp();
    return mk_rsp(rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_ovf, rsp_err);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int who, input logic [3:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [SHW-1:0] sh);
    if (who == 0) begin
      req0_valid = 1'b1; req0_opcode = op; req0_a = a; req0_b = b; req0_shift = sh;
    end else begin
      req1_valid = 1'b1; req1_opcode = op; req1_a = a; req1_b = b; req1_shift = sh;
    end
  endtask

  // Waits (bounded) for a response, snapshots it and completes the handshake when rsp_ready is high.
  task automatic collect(input int max_cycles, output bit got, output int waited, output rsp_t r);
    waited = 0;
    while (rsp_valid !== 1'b1 && waited < max_cycles) begin
      tick();
      waited++;
    end
    got = (rsp_valid === 1'b1);
    r = cur_rsp();
    $display("[TB] rsp got=%0b id=%0d result=%h c=%b z=%b o=%b err=%b after %0d cycles",
             got, r.id, r.result, r.carry, r.zero, r.ovf, r.err, waited);
    if (got && rsp_ready) tick();
  endtask

  task automatic pop_exp(output rsp_t e);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    tests_run++;
    if ({busy, rsp_valid, rsp_id, rsp_err, rsp_carry, rsp_zero, rsp_ovf} !== 7'd0) begin
      fails++; $display("FAIL reset_ctrl: got %b required 0000000", {busy, rsp_valid, rsp_id, rsp_err, rsp_carry, rsp_zero, rsp_ovf});
    end
    tests_run++;
    if ({alu_opcode, alu_input1, alu_input2, alu_shift} !== '0 || rsp_result !== '0) begin
      fails++; $display("FAIL reset_data: alu_opcode=%h in1=%h in2=%h shift=%h result=%h required all 0",
                        alu_opcode, alu_input1, alu_input2, alu_shift, rsp_result);
    end
    tests_run++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      fails++; $display("FAIL reset_ready: got %b required 00", {req0_ready, req1_ready});
    end
  endtask

  task automatic test_tie();
    bit got; int w; rsp_t r, e;
    for (int rep = 0; rep < 2; rep++) begin
      drive(0, 4'd7, 'hFF, 'hFF, '0);
      drive(1, 4'd5, 'hF0, 'h3C, '0);
      exp_q.push_back(mk_rsp(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0));
      exp_q.push_back(mk_rsp(1'b1, 'h30, 1'b0, 1'b0, 1'b0, 1'b0));
      #1;
      tests_run++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
        fails++; $display("FAIL tie_grant%0d: ready={r0,r1}=%b required 10", rep, {req0_ready, req1_ready});
      end
      tick();
      req0_valid = 1'b0;
      tests_run++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
        fails++; $display("FAIL tie_exec_ready%0d: got %b required 00", rep, {req0_ready, req1_ready});
      end
      collect(10, got, w, r);
      pop_exp(e);
      tests_run++;
      if (!got || w != 1 || r !== e) begin
        fails++; $display("FAIL tie_req0_rsp%0d: got=%b wait=%0d rsp=%h required wait=1 rsp=%h", rep, got, w, r, e);
      end
      tests_run++;
      if (req1_ready !== 1'b1) begin
        fails++; $display("FAIL tie_req1_next%0d: req1_ready=%b required 1", rep, req1_ready);
      end
      tick();
      req1_valid = 1'b0;
      collect(10, got, w, r);
      pop_exp(e);
      tests_run++;
      if (!got || r !== e) begin
        fails++; $display("FAIL tie_req1_rsp%0d: got=%b rsp=%h required %h", rep, got, r, e);
      end
    end
  endtask

  task automatic test_add();
    bit got; int w; rsp_t r, e;
    drive(0, 4'd6, 5, 7, '0);
    exp_q.push_back(mk_rsp(1'b0, 12, 1'b0, 1'b0, 1'b0, 1'b0));
    #1;
    tests_run++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      fails++; $display("FAIL add_ready: got %b required 10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 1'b0;
    tests_run++;
    if (alu_opcode !== 4'd6 || alu_input1 !== 5 || alu_input2 !== 7 || rsp_valid !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL add_t1: op=%h in1=%0d in2=%0d rsp_valid=%b busy=%b required 6/5/7/0/1",
                        alu_opcode, alu_input1, alu_input2, rsp_valid, busy);
    end
    collect(10, got, w, r);
    pop_exp(e);
    tests_run++;
    if (!got || w != 1 || r !== e) begin
      fails++; $display("FAIL add_rsp: got=%b wait=%0d rsp=%h required wait=1 rsp=%h", got, w, r, e);
    end
    tests_run++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL add_idle: busy=%b rsp_valid=%b required 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    bit got; int w; rsp_t r, e;
    drive(0, 4'd3, 3, 9, '0);
    exp_q.push_back(mk_rsp(1'b0, 27, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk_rsp(1'b1, 'h55, 1'b0, 1'b0, 1'b0, 1'b0));
    #1;
    tick();
    req0_valid = 1'b0;
    drive(1, 4'd4, 0, 'h55, '0);
    for (int i = 1; i <= MUL_LAT; i++) begin
      #1;
      tests_run++;
      if ({rsp_valid, req0_ready, req1_ready} !== 3'b000) begin
        fails++; $display("FAIL mul_exec_T%0d: {rsp_valid,r0,r1}=%b required 000", i, {rsp_valid, req0_ready, req1_ready});
      end
      tick();
    end
    tests_run++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b100) begin
      fails++; $display("FAIL mul_rsp_T%0d: {rsp_valid,r0,r1}=%b required 100", MUL_LAT + 1, {rsp_valid, req0_ready, req1_ready});
    end
    collect(0, got, w, r);
    pop_exp(e);
    tests_run++;
    if (!got || r !== e) begin
      fails++; $display("FAIL mul_result: got=%b rsp=%h required %h", got, r, e);
    end
    tests_run++;
    if (req1_ready !== 1'b1) begin
      fails++; $display("FAIL mul_then_req1: req1_ready=%b required 1", req1_ready);
    end
    tick();
    req1_valid = 1'b0;
    collect(10, got, w, r);
    pop_exp(e);
    tests_run++;
    if (!got || r !== e) begin
      fails++; $display("FAIL b2b_passb: got=%b rsp=%h required %h", got, r, e);
    end
  endtask

  task automatic test_illegal();
    bit got; int w; rsp_t r, e;
    drive(1, 4'd12, 'h1234, 'h5678, 5'd3);
    exp_q.push_back(mk_rsp(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b1));
    #1;
    tests_run++;
    if (req1_ready !== 1'b1) begin
      fails++; $display("FAIL illegal_ready: req1_ready=%b required 1", req1_ready);
    end
    tick();
    req1_valid = 1'b0;
    tests_run++;
    if (rsp_valid !== 1'b1 || alu_opcode !== 4'd12 || alu_input1 !== 'h1234) begin
      fails++; $display("FAIL illegal_t1: rsp_valid=%b alu_opcode=%0d in1=%h required 1/12/1234", rsp_valid, alu_opcode, alu_input1);
    end
    collect(0, got, w, r);
    pop_exp(e);
    tests_run++;
    if (!got || r !== e || busy !== 1'b0) begin
      fails++; $display("FAIL illegal_rsp: got=%b rsp=%h busy_after=%b required rsp=%h busy_after=0", got, r, busy, e);
    end
  endtask

  task automatic test_backpressure();
    bit got; int w; rsp_t r, e; bit bad = 0;
    rsp_ready = 1'b0;
    drive(0, 4'd4, 'h1234, 'hABCD, '0);
    exp_q.push_back(mk_rsp(1'b0, 'hABCD, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk_rsp(1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0));
    #1;
    tick();
    drive(0, 4'd6, 1, 2, '0);
    tick();
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b1 || rsp_result !== 'hABCD || req0_ready !== 1'b0) bad = 1;
      tick();
    end
    tests_run++;
    if (bad) begin
      fails++; $display("FAIL bp_hold: rsp_valid=%b result=%h req0_ready=%b required 1/abcd/0 for 10 cycles", rsp_valid, rsp_result, req0_ready);
    end
    rsp_ready = 1'b1;
    #1;
    tests_run++;
    if (req0_ready !== 1'b0) begin
      fails++; $display("FAIL bp_release_ready: req0_ready=%b required 0 during handshake", req0_ready);
    end
    collect(0, got, w, r);
    pop_exp(e);
    tests_run++;
    if (!got || r !== e) begin
      fails++; $display("FAIL bp_rsp: got=%b rsp=%h required %h", got, r, e);
    end
    tests_run++;
    if (req0_ready !== 1'b1) begin
      fails++; $display("FAIL bp_next_accept: req0_ready=%b required 1", req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    collect(10, got, w, r);
    pop_exp(e);
    tests_run++;
    if (!got || r !== e) begin
      fails++; $display("FAIL bp_second: got=%b rsp=%h required %h", got, r, e);
    end
  endtask

  typedef struct packed {
    logic [3:0] op; logic [WIDTH-1:0] a; logic [WIDTH-1:0] b; logic [SHW-1:0] sh;
    logic [WIDTH-1:0] res; logic c; logic z; logic o;
  } op_t;

  task automatic test_ops();
    bit got; int w; rsp_t r, e;
    op_t tbl[6];
    logic [WIDTH-1:0] ones = '1;
    logic [WIDTH-1:0] msb = '0;
    msb[WIDTH-1] = 1'b1;
    tbl[0] = '{op: 4'd0, a: 1, b: 0, sh: 5'd4, res: 'h10, c: 0, z: 0, o: 0};
    tbl[1] = '{op: 4'd1, a: ones, b: 1, sh: 0, res: 0, c: 0, z: 1, o: 0};
    tbl[2] = '{op: 4'd1, a: 5, b: ones, sh: 0, res: 1, c: 0, z: 0, o: 0};
    tbl[3] = '{op: 4'd2, a: 1, b: 0, sh: 5'd1, res: msb, c: 0, z: 0, o: 0};
    tbl[4] = '{op: 4'd6, a: ones, b: 1, sh: 0, res: 0, c: 1, z: 1, o: 0};
    tbl[5] = '{op: 4'd6, a: ones >> 1, b: 1, sh: 0, res: msb, c: 0, z: 0, o: 1};
    for (int i = 0; i < 6; i++) begin
      drive(i % 2, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh);
      exp_q.push_back(mk_rsp(1'((i % 2)), tbl[i].res, tbl[i].c, tbl[i].z, tbl[i].o, 1'b0));
      #1;
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      collect(10, got, w, r);
      pop_exp(e);
      tests_run++;
      if (!got || r !== e) begin
        fails++; $display("FAIL ops_%0d_op%0d: got=%b rsp=%h required %h", i, tbl[i].op, got, r, e);
      end
    end
  endtask

  task automatic test_reset_mid_mul();
    bit seen = 0;
    drive(0, 4'd3, 3, 9, '0);
    #1;
    tick();
    req0_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    tests_run++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL midreset_state: busy=%b rsp_valid=%b required 0 0", busy, rsp_valid);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid !== 1'b0) seen = 1;
      tick();
    end
    tests_run++;
    if (seen) begin
      fails++; $display("FAIL midreset_dropped: rsp_valid=1 seen required 0");
    end
    drive(0, 4'd4, 0, 1, '0);
    drive(1, 4'd4, 0, 2, '0);
    #1;
    tests_run++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      fails++; $display("FAIL midreset_tie: ready={r0,r1}=%b required 10", {req0_ready, req1_ready});
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_opcode = '0; req0_a = '0; req0_b = '0; req0_shift = '0;
    req1_valid = 1'b0; req1_opcode = '0; req1_a = '0; req1_b = '0; req1_shift = '0;
    test_reset();
    test_tie();
    test_add();
    test_back_to_back();
    test_illegal();
    test_backpressure();
    test_ops();
    test_reset_mid_mul();
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL scoreboard_empty: %0d entries left required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
